// File: rtl/image_scaler_pkg.sv
// Shared pixel type, 5-tap filter constants and the clamp-to-pixel helper
// for the image_scaler datapath.
package image_scaler_pkg;

    localparam int PIX_W = 8;
    typedef logic [PIX_W-1:0] pixel_t;

    localparam int TAP0  = -1;
    localparam int TAP1  = 4;
    localparam int TAP2  = 10;
    localparam int TAP3  = 4;
    localparam int TAP4  = -1;
    localparam int RND   = 8;
    localparam int SHIFT = 4;

    // Saturate a signed filter result into the unsigned w-bit pixel range.
    function automatic int clamp_pix(input int v, input int w);
        int pix_max;
        pix_max = (1 << w) - 1;
        if (v < 0)
            return 0;
        else if (v > pix_max)
            return pix_max;
        else
            return v;
    endfunction

endpackage

// File: rtl/image_scaler_fir5.sv
// Combinational 5-tap (-1,4,10,4,-1)/16 spatial filter with rounding and
// clamp, producing the spatial estimate S.
module image_scaler_fir5
    import image_scaler_pkg::*;
#(
    parameter int DATA_W = 8
) (
    input  logic [DATA_W-1:0] b0,
    input  logic [DATA_W-1:0] b1,
    input  logic [DATA_W-1:0] b2,
    input  logic [DATA_W-1:0] b3,
    input  logic [DATA_W-1:0] b4,
    output logic [DATA_W-1:0] s
);

    logic signed [31:0] acc;
    logic signed [31:0] acc_sh;

    always_comb begin
        acc    = TAP0 * int'(b0) + TAP1 * int'(b1) + TAP2 * int'(b2)
               + TAP3 * int'(b3) + TAP4 * int'(b4) + RND;
        // Arithmetic shift floors negative sums before the clamp.
        acc_sh = acc >>> SHIFT;
        s      = DATA_W'(clamp_pix(acc_sh, DATA_W));
    end

endmodule

// File: rtl/image_scaler.sv
// Two-stage edge-adaptive pixel interpolator. Define
// IMAGE_SCALER_EDGE_ADAPT_EN to enable gradient-based edge selection.
module image_scaler
    import image_scaler_pkg::*;
#(
    parameter int DATA_W  = 8,
    parameter int EDGE_TH = 32
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              in_valid,
    input  logic [DATA_W-1:0] B0,
    input  logic [DATA_W-1:0] B1,
    input  logic [DATA_W-1:0] B2,
    input  logic [DATA_W-1:0] B3,
    input  logic [DATA_W-1:0] B4,
    input  logic [DATA_W-1:0] T1,
    input  logic [DATA_W-1:0] T2,
    input  logic [DATA_W-1:0] T3,
    output logic [DATA_W-1:0] Tpix,
    output logic              out_valid
);

    function automatic logic [DATA_W-1:0] avg_round(input logic [DATA_W-1:0] a,
                                                     input logic [DATA_W-1:0] b);
        logic [DATA_W:0] sum;
        sum = {1'b0, a} + {1'b0, b} + (DATA_W+1)'(1);
        return DATA_W'(sum >> 1);
    endfunction

    logic [DATA_W-1:0] s_p0;
    logic [DATA_W-1:0] n_p0;
    logic [DATA_W+1:0] nsum_p0;
    logic              edge_p0;

    logic [DATA_W-1:0] s_p1;
    logic [DATA_W-1:0] n_p1;
    logic              edge_p1;
    logic              vld_p1;
    logic [DATA_W-1:0] pix_p1;

    // ---- stage 0: combinational estimates from the incoming sample ----
    image_scaler_fir5 #(
        .DATA_W (DATA_W)
    ) u_fir5 (
        .b0 (B0),
        .b1 (B1),
        .b2 (B2),
        .b3 (B3),
        .b4 (B4),
        .s  (s_p0)
    );

    assign nsum_p0 = {1'b0, T1, 1'b0} + {2'b00, T2} + {2'b00, T3} + (DATA_W+2)'(2);
    assign n_p0    = DATA_W'(nsum_p0 >> 2);

`ifdef IMAGE_SCALER_EDGE_ADAPT_EN
    localparam logic [DATA_W:0] TH = (DATA_W+1)'(EDGE_TH);
    logic [DATA_W-1:0] grad_p0;

    assign grad_p0 = (B1 >= B3) ? (B1 - B3) : (B3 - B1);
    assign edge_p0 = ({1'b0, grad_p0} > TH);
`else
    logic unused_edge_th;

    assign unused_edge_th = ^EDGE_TH;
    assign edge_p0        = 1'b0;
`endif

    // ---- stage 1 register ----
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            vld_p1  <= 1'b0;
            s_p1    <= '0;
            n_p1    <= '0;
            edge_p1 <= 1'b0;
        end else begin
            vld_p1 <= in_valid;
            if (in_valid) begin
                s_p1    <= s_p0;
                n_p1    <= n_p0;
                edge_p1 <= edge_p0;
            end
        end
    end

    assign pix_p1 = edge_p1 ? s_p1 : avg_round(s_p1, n_p1);

    // ---- stage 2 register: Tpix holds across bubbles ----
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid <= 1'b0;
            Tpix      <= '0;
        end else begin
            out_valid <= vld_p1;
            if (vld_p1)
                Tpix <= pix_p1;
        end
    end

endmodule

// File: tb/tb_image_scaler.sv
// Self-checking bench for image_scaler: directed literal cases plus random
// traffic checked every cycle against a behavioural reference.
module tb_image_scaler;

    localparam int DW  = 8;
    localparam int ETH = 32;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          in_valid;
    logic [DW-1:0] B0, B1, B2, B3, B4, T1, T2, T3;
    logic [DW-1:0] Tpix;
    logic          out_valid;

    int n_cmp = 0;
    int n_err = 0;

    image_scaler #(.DATA_W(DW), .EDGE_TH(ETH)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .B0        (B0),
        .B1        (B1),
        .B2        (B2),
        .B3        (B3),
        .B4        (B4),
        .T1        (T1),
        .T2        (T2),
        .T3        (T3),
        .Tpix      (Tpix),
        .out_valid (out_valid)
    );

    always #5 clk = ~clk;

    // Reference interpolation from plain integer arithmetic.
    function automatic logic [DW-1:0] ref_tpix(input int b0, input int b1, input int b2,
                                               input int b3, input int b4,
                                               input int t1, input int t2, input int t3);
        int sp, s, n, g, r;
        sp = -b0 + 4*b1 + 10*b2 + 4*b3 - b4 + 8;
        if (sp >= 0) s = sp / 16;
        else         s = -((-sp + 15) / 16);
        if (s < 0)   s = 0;
        if (s > 255) s = 255;
        n = (2*t1 + t2 + t3 + 2) / 4;
        g = (b1 > b3) ? b1 - b3 : b3 - b1;
        r = (s + n + 1) / 2;
`ifdef IMAGE_SCALER_EDGE_ADAPT_EN
        if (g > ETH) r = s;
`else
        if (g < 0) r = 0;
`endif
        return DW'(r);
    endfunction

    // Expected outputs: a sample accepted at one edge is visible after the next.
    logic          q_v   = 1'b0;
    logic [DW-1:0] q_d   = '0;
    logic          exp_ov = 1'b0;
    logic [DW-1:0] exp_tp = '0;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            q_v    = 1'b0;
            q_d    = '0;
            exp_ov = 1'b0;
            exp_tp = '0;
        end else begin
            exp_ov = q_v;
            if (q_v) exp_tp = q_d;
            q_v = in_valid;
            q_d = ref_tpix(B0, B1, B2, B3, B4, T1, T2, T3);
        end
    end

    always @(negedge clk) begin
        n_cmp++;
        if (out_valid !== exp_ov) begin
            n_err++;
            $display("FAIL out_valid t=%0t got %b want %b", $time, out_valid, exp_ov);
        end
        n_cmp++;
        if (Tpix !== exp_tp) begin
            n_err++;
            $display("FAIL Tpix t=%0t got %02h want %02h", $time, Tpix, exp_tp);
        end
    end

    task automatic drive(input logic v, input logic [DW-1:0] x0, x1, x2, x3, x4,
                         input logic [DW-1:0] y1, y2, y3);
        in_valid = v;
        B0 = x0; B1 = x1; B2 = x2; B3 = x3; B4 = x4;
        T1 = y1; T2 = y2; T3 = y3;
    endtask

    task automatic idle();
        in_valid = 1'b0;
    endtask

    // Apply one isolated sample and check the literal result two cycles later.
    task automatic directed(input string name, input logic [DW-1:0] x0, x1, x2, x3, x4,
                            input logic [DW-1:0] y1, y2, y3, input logic [DW-1:0] want);
        logic [DW-1:0] mdl;
        mdl = ref_tpix(x0, x1, x2, x3, x4, y1, y2, y3);
        n_cmp++;
        if (mdl !== want) begin
            n_err++;
            $display("FAIL model_%s got %02h want %02h", name, mdl, want);
        end
        @(negedge clk);
        drive(1'b1, x0, x1, x2, x3, x4, y1, y2, y3);
        @(negedge clk);
        idle();
        @(negedge clk);
        n_cmp++;
        if (out_valid !== 1'b1 || Tpix !== want) begin
            n_err++;
            $display("FAIL %s got ov=%b Tpix=%02h want ov=1 Tpix=%02h", name, out_valid, Tpix, want);
        end
    endtask

    function automatic logic [DW-1:0] rnd_pix();
        case ($urandom_range(0, 7))
            0:       return '0;
            1:       return '1;
            default: return DW'($urandom_range(0, 255));
        endcase
    endfunction

    initial begin
        #200000;
        $display("FAIL timeout");
        $fatal(1, "timeout");
    end

    initial begin
        rst_n = 1'b0;
        drive(1'b0, 0, 0, 0, 0, 0, 0, 0, 0);
        repeat (2) @(negedge clk);
        n_cmp++;
        if (Tpix !== 8'h00 || out_valid !== 1'b0) begin
            n_err++;
            $display("FAIL reset_state got ov=%b Tpix=%02h want ov=0 Tpix=00", out_valid, Tpix);
        end
        rst_n = 1'b1;
        @(negedge clk);

        directed("nominal", 8'hA9, 8'hA3, 8'hA3, 8'h9F, 8'h90, 8'h50, 8'h60, 8'h79, 8'h81);
        directed("flat", 8'h40, 8'h40, 8'h40, 8'h40, 8'h40, 8'h40, 8'h40, 8'h40, 8'h40);
`ifdef IMAGE_SCALER_EDGE_ADAPT_EN
        directed("edge", 8'h00, 8'h00, 8'h80, 8'hFF, 8'hFF, 8'h00, 8'h00, 8'h00, 8'h80);
`else
        directed("edge", 8'h00, 8'h00, 8'h80, 8'hFF, 8'hFF, 8'h00, 8'h00, 8'h00, 8'h40);
`endif
        directed("clamp_hi", 8'h00, 8'hFF, 8'hFF, 8'hFF, 8'h00, 8'hFF, 8'hFF, 8'hFF, 8'hFF);
        directed("clamp_lo", 8'hFF, 8'h00, 8'h00, 8'h00, 8'hFF, 8'h00, 8'h00, 8'h00, 8'h00);
        repeat (3) @(negedge clk);

        // Streaming with a one-cycle gap between the 2nd and 3rd samples.
        drive(1'b1, 8'h10, 8'h20, 8'h30, 8'h40, 8'h50, 8'h11, 8'h22, 8'h33);
        @(negedge clk);
        drive(1'b1, 8'hF0, 8'hE0, 8'hD0, 8'hC0, 8'hB0, 8'h99, 8'h88, 8'h77);
        @(negedge clk);
        idle();
        @(negedge clk);
        drive(1'b1, 8'h05, 8'h90, 8'h10, 8'h80, 8'h07, 8'h40, 8'hC0, 8'h20);
        @(negedge clk);
        drive(1'b1, 8'h33, 8'h66, 8'h99, 8'hCC, 8'hFF, 8'h01, 8'h02, 8'h03);
        @(negedge clk);
        idle();
        repeat (3) @(negedge clk);

        // Reset with two samples in flight.
        drive(1'b1, 8'h12, 8'h34, 8'h56, 8'h78, 8'h9A, 8'hBC, 8'hDE, 8'hF0);
        @(negedge clk);
        drive(1'b1, 8'hAA, 8'hBB, 8'hCC, 8'hDD, 8'hEE, 8'h11, 8'h22, 8'h33);
        @(negedge clk);
        idle();
        #2 rst_n = 1'b0;
        #1;
        n_cmp++;
        if (Tpix !== 8'h00 || out_valid !== 1'b0) begin
            n_err++;
            $display("FAIL async_reset got ov=%b Tpix=%02h want ov=0 Tpix=00", out_valid, Tpix);
        end
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        repeat (4) @(negedge clk);

        // Random traffic with frequent bubbles and saturating pixels.
        for (int i = 0; i < 400; i++) begin
            drive($urandom_range(0, 3) != 0, rnd_pix(), rnd_pix(), rnd_pix(), rnd_pix(),
                  rnd_pix(), rnd_pix(), rnd_pix(), rnd_pix());
            @(negedge clk);
        end
        idle();
        repeat (4) @(negedge clk);

        $display("== %0d vectors applied, %0d miscompares ==", n_cmp, n_err);
        $finish;
    end

endmodule
